// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control sequencer.
// State enum, write-back mux selects, opcode and ALU-op constants.
package ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXE    = 3'd2,
    NOP    = 3'd3,
    S_MEM  = 3'd4,
    L_MEM  = 3'd5,
    L_WB   = 3'd6,
    TRAP   = 3'd7
  } state_t;

  // Register-file write-data mux selects
  localparam logic [2:0] RWD_ALU   = 3'b000;
  localparam logic [2:0] RWD_LOAD  = 3'b001;
  localparam logic [2:0] RWD_LUI   = 3'b010;
  localparam logic [2:0] RWD_AUIPC = 3'b011;
  localparam logic [2:0] RWD_PC4   = 3'b100;

  // RV32I major opcodes
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_L     = 7'b0000011;

  // ALU op constants
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [2:0] F3_SHR   = 3'b101;

  // Opcodes that complete in a single EXE cycle
  function automatic logic is_exe_class(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_B: return 1'b1;
      default:                                             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational ALU-op decoder: instr_code -> {funct7[5], funct3}.
// Shared with the single-cycle core; loads/stores and U/J types use ADD.
module alu_op_decoder
  import ctrl_pkg::*;
(
  input  logic [31:0] instr_code,
  output logic [3:0]  alu_controls
);

  logic [6:0] opcode_s;
  logic [2:0] funct3_s;
  logic       unused_s;

  assign opcode_s = instr_code[6:0];
  assign funct3_s = instr_code[14:12];
  assign unused_s = ^{instr_code[31], instr_code[29:15], instr_code[11:7]};

  // Map opcode class to ALU op; only shifts-right look at funct7[5] for I-type
  always_comb begin
    alu_controls = ALU_ADD;
    case (opcode_s)
      OP_R: alu_controls = {instr_code[30], funct3_s};
      OP_I: begin
        if (funct3_s == F3_SHR) begin
          alu_controls = {instr_code[30], funct3_s};
        end else begin
          alu_controls = {1'b0, funct3_s};
        end
      end
      OP_B:    alu_controls = {1'b0, funct3_s};
      default: alu_controls = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control sequencer (FETCH/DECODE/EXE/MEM/WB) for the RV32I datapath.
// Drives datapath control fields, PC/IR strobes and a timed req/ready data-memory
// handshake. Optional macro ILLEGAL_TRAP_EN sends unknown opcodes to a sticky TRAP
// state; without it they retire as a no-op.
module multicycle_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_code,
  input  logic        d_ready,
  output logic        ir_en,
  output logic        pc_en,
  output logic [3:0]  alu_controls,
  output logic        reg_wr_en,
  output logic        d_req,
  output logic        d_wr_en,
  output logic [2:0]  d_func3,
  output logic        aluSrcMuxSel,
  output logic [2:0]  RegWdataSel,
  output logic        branch,
  output logic        jal,
  output logic        jalr,
  output logic        bus_err,
  output logic        illegal_instr
);

  state_t           state_r;
  state_t           next_state_s;
  logic [CNT_W-1:0] wait_cnt_r;
  logic [6:0]       opcode_s;
  logic [2:0]       funct3_s;
  logic             mem_st_s;
  logic             timeout_s;
  logic             unused_s;

  assign opcode_s  = instr_code[6:0];
  assign funct3_s  = instr_code[14:12];
  assign unused_s  = ^{instr_code[31:15], instr_code[11:7]};
  assign mem_st_s  = (state_r == S_MEM) || (state_r == L_MEM);
  // Completion wins over timeout when d_ready arrives on the last allowed cycle
  assign timeout_s = mem_st_s && !d_ready && (wait_cnt_r == CNT_W'(WAIT_MAX));

  alu_op_decoder u_alu_op_decoder (
    .instr_code   (instr_code),
    .alu_controls (alu_controls)
  );

  // Next-state selection
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      FETCH: next_state_s = DECODE;
      DECODE: begin
        if (is_exe_class(opcode_s)) begin
          next_state_s = EXE;
        end else if (opcode_s == OP_S) begin
          next_state_s = S_MEM;
        end else if (opcode_s == OP_L) begin
          next_state_s = L_MEM;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          next_state_s = TRAP;
`else
          next_state_s = NOP;
`endif
        end
      end
      EXE: next_state_s = FETCH;
      NOP: next_state_s = FETCH;
      S_MEM: begin
        if (d_ready || timeout_s) begin
          next_state_s = FETCH;
        end else begin
          next_state_s = S_MEM;
        end
      end
      L_MEM: begin
        if (d_ready) begin
          next_state_s = L_WB;
        end else if (timeout_s) begin
          next_state_s = FETCH;
        end else begin
          next_state_s = L_MEM;
        end
      end
      L_WB: next_state_s = FETCH;
`ifdef ILLEGAL_TRAP_EN
      TRAP: next_state_s = TRAP;
`else
      TRAP: next_state_s = FETCH;
`endif
      default: next_state_s = FETCH;
    endcase
  end

  // State register and memory wait counter (cleared in DECODE, the only way into a MEM state)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= FETCH;
      wait_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= next_state_s;
      if (state_r == DECODE) begin
        wait_cnt_r <= {CNT_W{1'b0}};
      end else if (mem_st_s && !d_ready) begin
        wait_cnt_r <= wait_cnt_r + CNT_W'(1);
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end
    end
  end

  // Moore output decode from state and instr_code; memory exit terms also see d_ready
  always_comb begin
    ir_en         = 1'b0;
    pc_en         = 1'b0;
    reg_wr_en     = 1'b0;
    d_req         = 1'b0;
    d_wr_en       = 1'b0;
    d_func3       = 3'b000;
    aluSrcMuxSel  = 1'b0;
    RegWdataSel   = RWD_ALU;
    branch        = 1'b0;
    jal           = 1'b0;
    jalr          = 1'b0;
    bus_err       = 1'b0;
    illegal_instr = 1'b0;
    case (state_r)
      // FETCH is also the reset state, so the IR strobe is held off while reset is low
      FETCH:  ir_en = reset;
      DECODE: ir_en = 1'b0;
      EXE: begin
        pc_en = 1'b1;
        case (opcode_s)
          OP_R: reg_wr_en = 1'b1;
          OP_I: begin
            reg_wr_en    = 1'b1;
            aluSrcMuxSel = 1'b1;
          end
          OP_LUI: begin
            reg_wr_en   = 1'b1;
            RegWdataSel = RWD_LUI;
          end
          OP_AUIPC: begin
            reg_wr_en   = 1'b1;
            RegWdataSel = RWD_AUIPC;
          end
          OP_JAL: begin
            reg_wr_en   = 1'b1;
            jal         = 1'b1;
            RegWdataSel = RWD_PC4;
          end
          OP_JALR: begin
            reg_wr_en   = 1'b1;
            jal         = 1'b1;
            jalr        = 1'b1;
            RegWdataSel = RWD_PC4;
          end
          OP_B:    branch = 1'b1;
          default: pc_en  = 1'b1;
        endcase
      end
      NOP: pc_en = 1'b1;
      S_MEM: begin
        d_req        = 1'b1;
        d_wr_en      = 1'b1;
        aluSrcMuxSel = 1'b1;
        d_func3      = funct3_s;
        pc_en        = d_ready || timeout_s;
        bus_err      = timeout_s;
      end
      L_MEM: begin
        d_req        = 1'b1;
        aluSrcMuxSel = 1'b1;
        d_func3      = funct3_s;
        pc_en        = timeout_s;
        bus_err      = timeout_s;
      end
      L_WB: begin
        reg_wr_en    = 1'b1;
        RegWdataSel  = RWD_LOAD;
        aluSrcMuxSel = 1'b1;
        d_func3      = funct3_s;
        pc_en        = 1'b1;
      end
`ifdef ILLEGAL_TRAP_EN
      TRAP: illegal_instr = 1'b1;
`else
      TRAP: illegal_instr = 1'b0;
`endif
      default: pc_en = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed self-checking bench for multicycle_ctrl_fsm.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_multicycle_ctrl_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_code;
  logic        d_ready;
  logic        ir_en, pc_en, reg_wr_en, d_req, d_wr_en, aluSrcMuxSel;
  logic        branch, jal, jalr, bus_err, illegal_instr;
  logic [3:0]  alu_controls;
  logic [2:0]  d_func3, RegWdataSel;
  logic [16:0] ov_s;

  int tests = 0;
  int fails = 0;

  localparam logic [31:0] I_ADD   = 32'h004182B3;
  localparam logic [31:0] I_SUB   = 32'h404182B3;
  localparam logic [31:0] I_SRAI  = 32'h40315093;
  localparam logic [31:0] I_ADDI  = 32'h40010093;
  localparam logic [31:0] I_LUI   = 32'h123450B7;
  localparam logic [31:0] I_AUIPC = 32'h12345097;
  localparam logic [31:0] I_JAL   = 32'h008000EF;
  localparam logic [31:0] I_JALR  = 32'h000100E7;
  localparam logic [31:0] I_BEQ   = 32'h00208463;
  localparam logic [31:0] I_LW    = 32'h00012083;
  localparam logic [31:0] I_SW    = 32'h00312223;
  localparam logic [31:0] I_SB    = 32'h00310023;
  localparam logic [31:0] I_ILL   = 32'h00000000;

  multicycle_ctrl_fsm #(.WAIT_MAX(15), .CNT_W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .instr_code    (instr_code),
    .d_ready       (d_ready),
    .ir_en         (ir_en),
    .pc_en         (pc_en),
    .alu_controls  (alu_controls),
    .reg_wr_en     (reg_wr_en),
    .d_req         (d_req),
    .d_wr_en       (d_wr_en),
    .d_func3       (d_func3),
    .aluSrcMuxSel  (aluSrcMuxSel),
    .RegWdataSel   (RegWdataSel),
    .branch        (branch),
    .jal           (jal),
    .jalr          (jalr),
    .bus_err       (bus_err),
    .illegal_instr (illegal_instr)
  );

  always #5 clk = ~clk;

  assign ov_s = {ir_en, pc_en, reg_wr_en, d_req, d_wr_en, aluSrcMuxSel, branch, jal, jalr,
                 bus_err, illegal_instr, RegWdataSel, d_func3};

  function automatic logic [16:0] mk(input logic ir, pc, rw, rq, wr, src, br, jl, jr, be, il,
                                     input logic [2:0] sel, f3);
    return {ir, pc, rw, rq, wr, src, br, jl, jr, be, il, sel, f3};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample the output vector at the falling edge, then advance to just after the next rising edge
  task automatic cyc(input string tag, input logic [16:0] exp);
    @(negedge clk);
    chk(tag, {15'd0, ov_s}, {15'd0, exp});
    @(posedge clk);
    #1;
  endtask

  // FETCH, IR load, DECODE (ALU op check), EXE
  task automatic run_exe(input string tag, input logic [31:0] ins, input logic [3:0] alu_exp,
                         input logic [16:0] exe_exp);
    cyc({tag, ".fetch"}, mk(1,0,0,0,0,0,0,0,0,0,0,3'b000,3'b000));
    instr_code = ins;
    #1;
    chk({tag, ".alu"}, {28'd0, alu_controls}, {28'd0, alu_exp});
    cyc({tag, ".dec"}, 17'd0);
    cyc({tag, ".exe"}, exe_exp);
  endtask

  initial begin
    reset      = 1'b0;
    instr_code = 32'd0;
    d_ready    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.outs", {15'd0, ov_s}, 32'd0);
    chk("rst.alu", {28'd0, alu_controls}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Single-EXE-cycle classes
    run_exe("add",   I_ADD,   4'b0000, mk(0,1,1,0,0,0,0,0,0,0,0,3'b000,3'b000));
    run_exe("sub",   I_SUB,   4'b1000, mk(0,1,1,0,0,0,0,0,0,0,0,3'b000,3'b000));
    run_exe("srai",  I_SRAI,  4'b1101, mk(0,1,1,0,0,1,0,0,0,0,0,3'b000,3'b000));
    run_exe("addi",  I_ADDI,  4'b0000, mk(0,1,1,0,0,1,0,0,0,0,0,3'b000,3'b000));
    run_exe("lui",   I_LUI,   4'b0000, mk(0,1,1,0,0,0,0,0,0,0,0,3'b010,3'b000));
    run_exe("auipc", I_AUIPC, 4'b0000, mk(0,1,1,0,0,0,0,0,0,0,0,3'b011,3'b000));
    run_exe("jal",   I_JAL,   4'b0000, mk(0,1,1,0,0,0,0,1,0,0,0,3'b100,3'b000));
    run_exe("beq",   I_BEQ,   4'b0000, mk(0,1,0,0,0,0,1,0,0,0,0,3'b000,3'b000));
    // d_ready is ignored outside memory states
    d_ready = 1'b1;
    run_exe("jalr",  I_JALR,  4'b0000, mk(0,1,1,0,0,0,0,1,1,0,0,3'b100,3'b000));
    d_ready = 1'b0;

    // lw with three wait cycles: 4 cycles of d_req, then write-back
    cyc("lw.fetch", mk(1,0,0,0,0,0,0,0,0,0,0,3'b000,3'b000));
    instr_code = I_LW;
    #1;
    chk("lw.alu", {28'd0, alu_controls}, 32'd0);
    cyc("lw.dec", 17'd0);
    for (int i = 0; i < 3; i++) cyc($sformatf("lw.wait%0d", i), mk(0,0,0,1,0,1,0,0,0,0,0,3'b000,3'b010));
    d_ready = 1'b1;
    cyc("lw.done", mk(0,0,0,1,0,1,0,0,0,0,0,3'b000,3'b010));
    d_ready = 1'b0;
    cyc("lw.wb", mk(0,1,1,0,0,1,0,0,0,0,0,3'b001,3'b010));

    // sw that never completes: abort on the 16th d_req cycle
    cyc("sw.fetch", mk(1,0,0,0,0,0,0,0,0,0,0,3'b000,3'b000));
    instr_code = I_SW;
    cyc("sw.dec", 17'd0);
    for (int i = 0; i < 15; i++) cyc($sformatf("sw.wait%0d", i), mk(0,0,0,1,1,1,0,0,0,0,0,3'b000,3'b010));
    cyc("sw.abort", mk(0,1,0,1,1,1,0,0,0,1,0,3'b000,3'b010));

    // sb completing on the last allowed cycle: completion wins, no bus_err
    cyc("sb.fetch", mk(1,0,0,0,0,0,0,0,0,0,0,3'b000,3'b000));
    instr_code = I_SB;
    cyc("sb.dec", 17'd0);
    for (int i = 0; i < 15; i++) cyc($sformatf("sb.wait%0d", i), mk(0,0,0,1,1,1,0,0,0,0,0,3'b000,3'b000));
    d_ready = 1'b1;
    cyc("sb.done", mk(0,1,0,1,1,1,0,0,0,0,0,3'b000,3'b000));
    d_ready = 1'b0;

    // Reset asserted mid L_MEM: d_req drops before the next edge
    cyc("rl.fetch", mk(1,0,0,0,0,0,0,0,0,0,0,3'b000,3'b000));
    instr_code = I_LW;
    cyc("rl.dec", 17'd0);
    cyc("rl.lmem", mk(0,0,0,1,0,1,0,0,0,0,0,3'b000,3'b010));
    #2;
    reset = 1'b0;
    #1;
    chk("rl.dreq", {31'd0, d_req}, 32'd0);
    chk("rl.outs", {15'd0, ov_s}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    run_exe("postrst", I_ADD, 4'b0000, mk(0,1,1,0,0,0,0,0,0,0,0,3'b000,3'b000));

    // Unknown opcode
    cyc("ill.fetch", mk(1,0,0,0,0,0,0,0,0,0,0,3'b000,3'b000));
    instr_code = I_ILL;
    cyc("ill.dec", 17'd0);
`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 4; i++) cyc($sformatf("ill.trap%0d", i), mk(0,0,0,0,0,0,0,0,0,0,1,3'b000,3'b000));
    reset = 1'b0;
    #1;
    chk("ill.rst", {15'd0, ov_s}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
`else
    cyc("ill.nop", mk(0,1,0,0,0,0,0,0,0,0,0,3'b000,3'b000));
`endif
    cyc("ill.next", mk(1,0,0,0,0,0,0,0,0,0,0,3'b000,3'b000));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Multi-cycle sequencer for the RV32I datapath. It replaces single-cycle control with a FETCH/DECODE/EXECUTE/MEM/WB state machine.
- It drives the existing datapath control fields (alu_controls, RegWdataSel, jal/jalr/branch, and the others), adds PC/IR latch strobes, and runs a req/ready handshake to data memory with a timeout.
- It sits between the instruction register and the datapath. instr_code comes from the IR, which this block loads.

Parameters:
- WAIT_MAX, 15: maximum data-memory wait cycles before abort; 1..255.
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > WAIT_MAX.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- instr_code  in  32  current instruction from the IR; stable from DECODE to end of instruction
- d_ready  in  1  data memory access complete; sampled only while d_req=1
- ir_en  out  1  IR load strobe
- pc_en  out  1  PC update strobe; exactly one cycle per retired instruction
- alu_controls  out  4  ALU op {funct7[5], funct3}; ADD for load/store
- reg_wr_en  out  1  register file write enable
- d_req  out  1  data memory request
- d_wr_en  out  1  data memory write, valid with d_req
- d_func3  out  3  load/store size/sign = funct3 during MEM states, else 0
- aluSrcMuxSel  out  1  0 = rs2, 1 = immediate
- RegWdataSel  out  3  000 ALU, 001 load, 010 LUI, 011 AUIPC, 100 PC+4
- branch, jal, jalr  out  1 each  PC-select controls, asserted only in the cycle pc_en=1
- bus_err  out  1  one-cycle pulse on memory timeout
- illegal_instr  out  1  sticky illegal-opcode flag (see Optional Feature)

Behaviour:
- Reset (async, reset=0): state=FETCH, wait counter=0. All outputs 0, except alu_controls=0000 and RegWdataSel=000. d_req falls immediately, even mid-access. Exit from reset is synchronous to clk.
- Output style: Moore, decoded from state and instr_code. alu_controls is combinational from instr_code in every state and follows the single-cycle encoding, including SRAI/SRLI via funct7[5] for I-type.
- FETCH: ir_en=1 → DECODE.
- DECODE: no strobes. Next state by opcode:
  - R, I, LUI, AUIPC, JAL, JALR, B → EXE
  - S → S_MEM
  - L → L_MEM
  - any other opcode → NOP
- EXE: asserts, in one cycle, the class fields plus pc_en=1:
  - R: reg_wr_en=1
  - I: reg_wr_en=1, aluSrc=1
  - LUI: reg_wr_en=1, RegWdataSel=010
  - AUIPC: reg_wr_en=1, RegWdataSel=011
  - JAL: reg_wr_en=1, jal=1, RegWdataSel=100
  - JALR: reg_wr_en=1, jal=1, jalr=1, RegWdataSel=100
  - B: branch=1, no register write
  - → FETCH
- NOP: pc_en=1 → FETCH.
- S_MEM: d_req=1, d_wr_en=1, aluSrc=1, d_func3=funct3.
  - d_ready=1 → pc_en=1 same cycle → FETCH.
- L_MEM: d_req=1, d_wr_en=0, aluSrc=1, d_func3=funct3.
  - d_ready=1 → L_WB.
- L_WB: reg_wr_en=1, RegWdataSel=001, aluSrc=1, d_func3=funct3, pc_en=1 → FETCH.
- Wait counter:
  - Clears on entry to any MEM state.
  - Increments each MEM cycle with d_ready=0.
  - Counter == WAIT_MAX with d_ready=0 → abort: bus_err=1 and pc_en=1 that cycle, no reg write, → FETCH.
  - d_ready=1 in the same cycle the counter hits WAIT_MAX: completion wins, no bus_err.
- d_ready outside MEM states is ignored.
- d_req is held continuously through a MEM state; no deassertion between wait cycles.
- CPI with zero waits: R/I/U/J/B = 3, S = 3, L = 4. Each wait cycle adds 1.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: an unknown opcode in DECODE → TRAP. TRAP sets illegal_instr=1 and holds it; no pc_en, ir_en or writes; exit only by reset.
- Undefined: unknown opcode → NOP state, executed as a 3-cycle no-op; illegal_instr is tied 0 and no TRAP state exists.

Decomposition:
- Package ctrl_pkg holds the state enum typedef: FETCH, DECODE, EXE, NOP, S_MEM, L_MEM, L_WB, TRAP.
- The RegWdataSel encodings also go in ctrl_pkg as named localparams.
- Opcode and ALU op macros stay in define.sv.
- One sub-module, alu_op_decoder: purely combinational, instr_code → alu_controls, reusable by the single-cycle core.

Test Plan:
- add x5,x3,x4 (32'h004182B3) → ir_en at cycle 0, reg_wr_en and pc_en together at cycle 2, alu_controls=0000, RegWdataSel=000; next ir_en at cycle 3.
- lw with d_ready held 3 cycles late → d_req high for 4 consecutive cycles, d_func3=010, then L_WB with reg_wr_en=1, RegWdataSel=001, pc_en=1; total 7 cycles.
- sw with d_ready never asserted, WAIT_MAX=15 → d_req high for 16 cycles, bus_err pulse on the 16th together with pc_en, no reg_wr_en, then FETCH.
- reset driven low during L_MEM (d_req=1) → d_req=0 asynchronously before the next clk edge; after release, the first cycle shows ir_en=1.
- opcode 7'b0000000 → without ILLEGAL_TRAP_EN: pc_en at cycle 2, no writes; with it: illegal_instr=1 sticky, pc_en never asserts.
- jalr → in cycle 2: jal=1, jalr=1, RegWdataSel=100, reg_wr_en=1, pc_en=1, all simultaneously.
